// File: rtl/smart_cargo_pkg.sv
// smart_cargo_pkg: shared FSM states, default timing constants and floor-to-one-hot helper.
package smart_cargo_pkg;
  typedef enum logic [2:0] {IDLE, ORIGEM, GAP1, DESTINO, GAP2} state_t;
  localparam int HOLD_DEF = 4;
  localparam int GAP_DEF = 2;
  function automatic logic [3:0] floor_onehot(input logic [1:0] f);
    return 4'b0001 << f;
  endfunction
endpackage

// File: rtl/smart_cargo_fila_req.sv
// smart_cargo_fila_req: request buffer, sync FIFO with async active-low clear.
module smart_cargo_fila_req #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     nivel,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] nivel_q;
  logic push_ok, pop_ok;
  assign full = nivel_q == (AW+1)'(DEPTH);
  assign empty = nivel_q == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign dout = mem_q[rd_q];
  assign nivel = nivel_q;
  // Pointers are AW bits wide over a power-of-two depth, so they wrap on their own.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      nivel_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      nivel_q <= nivel_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge clock)
    if (push_ok) mem_q[wr_q] <= din;
endmodule

// File: rtl/smart_cargo_painel_tx.sv
// smart_cargo_painel_tx: buffers floor requests and replays them as timed one-hot button codes.
// Define SMART_CARGO_DROP_REPEAT_EN to discard requests whose origin equals destination.
module smart_cargo_painel_tx
  import smart_cargo_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int GAP_CYCLES = GAP_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [1:0]                    req_origem,
  input  logic [1:0]                    req_destino,
  output logic                          req_ready,
  input  logic                          elev_pronto,
  output logic [3:0]                    origemBot,
  output logic [3:0]                    destinoBot,
  output logic                          ocupado,
  output logic [$clog2(FIFO_DEPTH):0]   nivel,
  output logic                          erro_repetido
);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t state_q;
  logic [3:0] cnt_q, orig_bot_q, dest_bot_q, head;
  logic [1:0] dest_q;
  logic ocup_q, erro_q, rdy_q, full, empty, push, pop, drop;
  assign req_ready = rdy_q & ~full;
  assign push = req_valid & req_ready;
  assign pop = (state_q == IDLE) & ~empty & elev_pronto;
  assign origemBot = orig_bot_q;
  assign destinoBot = dest_bot_q;
  assign ocupado = ocup_q;
  assign erro_repetido = erro_q;
`ifdef SMART_CARGO_DROP_REPEAT_EN
  assign drop = head[3:2] == head[1:0];
`else
  assign drop = 1'b0;
`endif
  smart_cargo_fila_req #(.DEPTH(FIFO_DEPTH), .W(4)) u_fila (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({req_origem, req_destino}),
    .dout(head),
    .nivel(nivel),
    .full(full),
    .empty(empty)
  );
  // Codes are loaded one cycle ahead of the state they belong to, so they line up with it.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dest_q <= '0;
      orig_bot_q <= '0;
      dest_bot_q <= '0;
      ocup_q <= 1'b0;
      erro_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      erro_q <= 1'b0;
      cnt_q <= state_q == IDLE ? 4'd0 : cnt_q + 4'd1;
      case (state_q)
        IDLE:
          if (pop) begin
            if (drop) erro_q <= 1'b1;
            else begin
              state_q <= ORIGEM;
              dest_q <= head[1:0];
              orig_bot_q <= floor_onehot(head[3:2]);
              ocup_q <= 1'b1;
            end
          end
        ORIGEM:
          if (cnt_q == HOLD_LAST) begin
            state_q <= GAP1;
            cnt_q <= '0;
            orig_bot_q <= '0;
          end
        GAP1:
          if (cnt_q == GAP_LAST) begin
            state_q <= DESTINO;
            cnt_q <= '0;
            dest_bot_q <= floor_onehot(dest_q);
          end
        DESTINO:
          if (cnt_q == HOLD_LAST) begin
            state_q <= GAP2;
            cnt_q <= '0;
            dest_bot_q <= '0;
          end
        GAP2:
          if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ocup_q <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_smart_cargo_painel_tx.sv
// tb_smart_cargo_painel_tx: directed self-checking bench for smart_cargo_painel_tx (default parameters).
module tb_smart_cargo_painel_tx;
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, elev_pronto = 1'b0;
  logic [1:0] req_origem = '0, req_destino = '0;
  logic req_ready, ocupado, erro_repetido;
  logic [3:0] origemBot, destinoBot;
  logic [2:0] nivel;
  int n_chk = 0, n_fail = 0, busy;

  always #5 clock = ~clock;

  smart_cargo_painel_tx dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_origem(req_origem),
    .req_destino(req_destino),
    .req_ready(req_ready),
    .elev_pronto(elev_pronto),
    .origemBot(origemBot),
    .destinoBot(destinoBot),
    .ocupado(ocupado),
    .nivel(nivel),
    .erro_repetido(erro_repetido)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [1:0] o, input logic [1:0] d);
    req_valid = v;
    req_origem = o;
    req_destino = d;
    @(negedge clock);
  endtask

  // Waits (bounded) for the frame to start, then checks all 12 busy cycles and the idle cycle after.
  task automatic expect_frame(input logic [1:0] o, input logic [1:0] d, input int drop_at, input string tag);
    int t = 0;
    while (ocupado !== 1'b1 && t < 40) begin
      @(negedge clock);
      t++;
    end
    check({tag, " start"}, 32'(ocupado), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check({tag, " orig"}, 32'(origemBot), i < 4 ? 32'(4'b0001 << o) : 32'd0);
      check({tag, " dest"}, 32'(destinoBot), (i >= 6 && i < 10) ? 32'(4'b0001 << d) : 32'd0);
      check({tag, " ocup"}, 32'(ocupado), 32'd1);
      if (i == drop_at) elev_pronto = 1'b0;
      @(negedge clock);
    end
    check({tag, " end"}, 32'(ocupado), 32'd0);
  endtask

  task automatic count_busy(input int n);
    busy = 0;
    repeat (n) begin
      @(negedge clock);
      if (ocupado !== 1'b0 || origemBot !== 4'd0 || destinoBot !== 4'd0) busy++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst orig", 32'(origemBot), 32'd0);
    check("rst dest", 32'(destinoBot), 32'd0);
    check("rst ocup", 32'(ocupado), 32'd0);
    check("rst erro", 32'(erro_repetido), 32'd0);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst nivel", 32'(nivel), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("ready before edge", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("ready after edge", 32'(req_ready), 32'd1);
    // Single request 1 -> 3
    elev_pronto = 1'b1;
    offer(1'b1, 2'd1, 2'd3);
    req_valid = 1'b0;
    check("t1 no bypass", 32'(origemBot), 32'd0);
    check("t1 nivel", 32'(nivel), 32'd1);
    expect_frame(2'd1, 2'd3, -1, "t1");
    // Fill while elevator busy, fifth push ignored, then pop+push while full
    elev_pronto = 1'b0;
    offer(1'b1, 2'd0, 2'd1);
    offer(1'b1, 2'd1, 2'd2);
    offer(1'b1, 2'd2, 2'd3);
    offer(1'b1, 2'd3, 2'd0);
    check("t2 full ready", 32'(req_ready), 32'd0);
    offer(1'b1, 2'd0, 2'd2);
    req_valid = 1'b0;
    check("t2 nivel full", 32'(nivel), 32'd4);
    check("t2 ready full", 32'(req_ready), 32'd0);
    elev_pronto = 1'b1;
    offer(1'b1, 2'd3, 2'd3);
    req_valid = 1'b0;
    check("t2 full pop+push nivel", 32'(nivel), 32'd3);
    expect_frame(2'd0, 2'd1, -1, "t2r1");
    expect_frame(2'd1, 2'd2, -1, "t2r2");
    expect_frame(2'd2, 2'd3, -1, "t2r3");
    expect_frame(2'd3, 2'd0, -1, "t2r4");
    count_busy(15);
    check("t2 no extra frame", 32'(busy), 32'd0);
    check("t2 nivel drained", 32'(nivel), 32'd0);
    // Simultaneous push/pop, then elevator not ready dropped during GAP1
    offer(1'b1, 2'd3, 2'd1);
    check("t3 nivel push", 32'(nivel), 32'd1);
    offer(1'b1, 2'd1, 2'd2);
    req_valid = 1'b0;
    check("t3 push+pop nivel", 32'(nivel), 32'd1);
    expect_frame(2'd3, 2'd1, 4, "t3a");
    count_busy(6);
    check("t3 waits for pronto", 32'(busy), 32'd0);
    check("t3 nivel held", 32'(nivel), 32'd1);
    elev_pronto = 1'b1;
    expect_frame(2'd1, 2'd2, -1, "t3b");
    // Repeated floor request
    offer(1'b1, 2'd2, 2'd2);
    req_valid = 1'b0;
`ifdef SMART_CARGO_DROP_REPEAT_EN
    @(negedge clock);
    check("t4 erro pulse", 32'(erro_repetido), 32'd1);
    check("t4 no ocup", 32'(ocupado), 32'd0);
    @(negedge clock);
    check("t4 erro end", 32'(erro_repetido), 32'd0);
    count_busy(14);
    check("t4 no codes", 32'(busy), 32'd0);
    check("t4 nivel", 32'(nivel), 32'd0);
`else
    check("t4 erro tied", 32'(erro_repetido), 32'd0);
    expect_frame(2'd2, 2'd2, -1, "t4");
    check("t4 erro after", 32'(erro_repetido), 32'd0);
`endif
    // Reset in second DESTINO cycle with one request still buffered
    offer(1'b1, 2'd0, 2'd1);
    offer(1'b1, 2'd2, 2'd3);
    req_valid = 1'b0;
    check("t5 started", 32'(ocupado), 32'd1);
    repeat (7) @(negedge clock);
    check("t5 destino", 32'(destinoBot), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t5 async dest", 32'(destinoBot), 32'd0);
    check("t5 async orig", 32'(origemBot), 32'd0);
    check("t5 async ocup", 32'(ocupado), 32'd0);
    check("t5 async nivel", 32'(nivel), 32'd0);
    check("t5 async ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5 ready", 32'(req_ready), 32'd1);
    count_busy(30);
    check("t5 silent", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
